// File: rtl/bram_heap_pq.sv
// Binary min-heap priority queue backed by a single simple-dual-port RAM.
// The root is mirrored in a register so a dequeue returns data without a RAM read.
module bram_heap_pq #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 256
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         i_enq,
  input  logic [DATA_WIDTH-1:0]        i_enq_data,
  input  logic                         i_deq,
  output logic                         o_ready,
  output logic                         o_deq_valid,
  output logic [DATA_WIDTH-1:0]        o_deq_data,
  output logic [$clog2(RAM_DEPTH):0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, UP_RD, UP_CMP, DN_RDL, DN_RDR, DN_CMP, FETCH_LAST} state_t;

  logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ram_we;
  logic [AW-1:0]         ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         hole_q, hole_d;
  logic [DATA_WIDTH-1:0] item_q, item_d;
  logic [DATA_WIDTH-1:0] root_q, root_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic                  has_right_q, has_right_d;
  logic                  deq_valid_q, deq_valid_d;
  logic [DATA_WIDTH-1:0] deq_data_q, deq_data_d;

  logic [AW+1:0]         left_idx, right_idx, count_ext;
  logic [AW-1:0]         parent_idx;

  always_ff @(posedge CLK) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    rdata_q <= ram[ram_raddr];
  end

  always_comb begin
    left_idx   = {1'b0, hole_q, 1'b1};
    right_idx  = left_idx + (AW+2)'(1);
    count_ext  = {1'b0, count_q};
    parent_idx = (hole_q - AW'(1)) >> 1;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    hole_d      = hole_q;
    item_d      = item_q;
    root_d      = root_q;
    left_d      = left_q;
    has_right_d = has_right_q;
    deq_valid_d = 1'b0;
    deq_data_d  = deq_data_q;
    ram_we      = 1'b0;
    ram_waddr   = '0;
    ram_wdata   = '0;
    ram_raddr   = '0;

    case (state_q)
      IDLE: begin
        // Enqueue wins when empty, so enq+deq on an empty queue is a plain enqueue.
        if (i_enq && (!i_deq || count_q == '0) && !o_full) begin
          count_d = count_q + CW'(1);
          item_d  = i_enq_data;
          hole_d  = AW'(count_q);
          if (count_q == '0) begin
            ram_we    = 1'b1;
            ram_waddr = '0;
            ram_wdata = i_enq_data;
          end else begin
            state_d = UP_RD;
          end
        end else if (i_deq && count_q != '0) begin
          deq_valid_d = 1'b1;
          deq_data_d  = root_q;
          hole_d      = '0;
          if (i_enq) begin
            item_d  = i_enq_data;
            state_d = DN_RDL;
          end else begin
            count_d = count_q - CW'(1);
            if (count_q != CW'(1)) begin
              ram_raddr = AW'(count_q - CW'(1));
              state_d   = FETCH_LAST;
            end
          end
        end
      end
      FETCH_LAST: begin
        item_d  = rdata_q;
        state_d = DN_RDL;
      end
      UP_RD: begin
        if (hole_q == '0) begin
          ram_we    = 1'b1;
          ram_waddr = hole_q;
          ram_wdata = item_q;
          state_d   = IDLE;
        end else begin
          ram_raddr = parent_idx;
          state_d   = UP_CMP;
        end
      end
      UP_CMP: begin
        ram_we    = 1'b1;
        ram_waddr = hole_q;
        if (item_q < rdata_q) begin
          ram_wdata = rdata_q;
          hole_d    = parent_idx;
          state_d   = UP_RD;
        end else begin
          ram_wdata = item_q;
          state_d   = IDLE;
        end
      end
      DN_RDL: begin
        if (left_idx < count_ext) begin
          ram_raddr = AW'(left_idx);
          state_d   = DN_RDR;
        end else begin
          ram_we    = 1'b1;
          ram_waddr = hole_q;
          ram_wdata = item_q;
          state_d   = IDLE;
        end
      end
      DN_RDR: begin
        left_d      = rdata_q;
        has_right_d = right_idx < count_ext;
        if (right_idx < count_ext) ram_raddr = AW'(right_idx);
        state_d = DN_CMP;
      end
      DN_CMP: begin
        ram_we    = 1'b1;
        ram_waddr = hole_q;
        // Right child only wins when strictly smaller, so ties favour the left.
        if (has_right_q && rdata_q < left_q && rdata_q < item_q) begin
          ram_wdata = rdata_q;
          hole_d    = AW'(right_idx);
          state_d   = DN_RDL;
        end else if (!(has_right_q && rdata_q < left_q) && left_q < item_q) begin
          ram_wdata = left_q;
          hole_d    = AW'(left_idx);
          state_d   = DN_RDL;
        end else begin
          ram_wdata = item_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ram_we && ram_waddr == '0) root_d = ram_wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      count_q     <= '0;
      hole_q      <= '0;
      item_q      <= '0;
      root_q      <= '0;
      left_q      <= '0;
      has_right_q <= 1'b0;
      deq_valid_q <= 1'b0;
      deq_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      hole_q      <= hole_d;
      item_q      <= item_d;
      root_q      <= root_d;
      left_q      <= left_d;
      has_right_q <= has_right_d;
      deq_valid_q <= deq_valid_d;
      deq_data_q  <= deq_data_d;
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_deq_valid = deq_valid_q;
  assign o_deq_data  = deq_data_q;
  assign o_count     = count_q;
  assign o_full      = (count_q == CW'(RAM_DEPTH));
  assign o_empty     = (count_q == '0);
endmodule

// File: tb/tb_bram_heap_pq.sv
// Directed bench for bram_heap_pq: ordering, replace-top, empty/full edges and mid-sift reset.
module tb_bram_heap_pq;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int BOUND = 3 * $clog2(DEPTH) + 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          i_enq = 1'b0;
  logic [DW-1:0] i_enq_data = '0;
  logic          i_deq = 1'b0;
  logic          o_ready, o_deq_valid, o_full, o_empty;
  logic [DW-1:0] o_deq_data;
  logic [CW-1:0] o_count;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] keys [DEPTH];
  logic [DW-1:0] tmp;

  bram_heap_pq #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .i_enq(i_enq), .i_enq_data(i_enq_data), .i_deq(i_deq),
    .o_ready(o_ready), .o_deq_valid(o_deq_valid), .o_deq_data(o_deq_data),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < BOUND) begin
      @(negedge CLK);
      n++;
    end
    check("ready_within_bound", {31'b0, o_ready}, 32'd1);
  endtask

  task automatic do_enq(input logic [DW-1:0] d);
    wait_ready();
    i_enq = 1'b1;
    i_enq_data = d;
    @(negedge CLK);
    i_enq = 1'b0;
  endtask

  task automatic do_deq(input string tag, input logic [DW-1:0] exp);
    wait_ready();
    i_deq = 1'b1;
    @(negedge CLK);
    i_deq = 1'b0;
    check({tag, "_valid"}, {31'b0, o_deq_valid}, 32'd1);
    check(tag, {16'b0, o_deq_data}, {16'b0, exp});
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check("rst_ready", {31'b0, o_ready}, 32'd1);
    check("rst_valid", {31'b0, o_deq_valid}, 32'd0);
    check("rst_data", {16'b0, o_deq_data}, 32'd0);
    check("rst_count", {27'b0, o_count}, 32'd0);
    check("rst_empty", {31'b0, o_empty}, 32'd1);
    check("rst_full", {31'b0, o_full}, 32'd0);

    // Basic ordering
    do_enq(5);
    check("count_after_first_enq", {27'b0, o_count}, 32'd1);
    do_enq(3); do_enq(8); do_enq(1);
    wait_ready();
    check("count4", {27'b0, o_count}, 32'd4);
    do_deq("basic0", 1);
    check("count_after_deq", {27'b0, o_count}, 32'd3);
    do_deq("basic1", 3);
    do_deq("basic2", 5);
    do_deq("basic3", 8);
    check("basic_empty", {31'b0, o_empty}, 32'd1);

    // Empty queue edges
    wait_ready();
    i_deq = 1'b1;
    @(negedge CLK);
    i_deq = 1'b0;
    check("empty_deq_no_valid", {31'b0, o_deq_valid}, 32'd0);
    check("empty_deq_count", {27'b0, o_count}, 32'd0);
    wait_ready();
    i_enq = 1'b1; i_deq = 1'b1; i_enq_data = 6;
    @(negedge CLK);
    i_enq = 1'b0; i_deq = 1'b0;
    check("empty_both_no_valid", {31'b0, o_deq_valid}, 32'd0);
    check("empty_both_count", {27'b0, o_count}, 32'd1);
    do_deq("empty_both_drain", 6);

    // Duplicates
    do_enq(4); do_enq(4); do_enq(4);
    do_deq("dup0", 4); do_deq("dup1", 4); do_deq("dup2", 4);
    check("dup_empty", {31'b0, o_empty}, 32'd1);

    // Replace-top
    do_enq(2); do_enq(7); do_enq(9);
    wait_ready();
    i_enq = 1'b1; i_deq = 1'b1; i_enq_data = 4;
    @(negedge CLK);
    i_enq = 1'b0; i_deq = 1'b0;
    check("rt_valid", {31'b0, o_deq_valid}, 32'd1);
    check("rt_data", {16'b0, o_deq_data}, 32'd2);
    check("rt_count", {27'b0, o_count}, 32'd3);
    do_deq("rt0", 4); do_deq("rt1", 7); do_deq("rt2", 9);

    // Fill to full with random keys, then drain sorted
    for (int i = 0; i < DEPTH; i++) begin
      keys[i] = DW'($urandom_range(0, 65535));
      do_enq(keys[i]);
    end
    wait_ready();
    check("fill_full", {31'b0, o_full}, 32'd1);
    check("fill_count", {27'b0, o_count}, DEPTH);
    i_enq = 1'b1; i_enq_data = 0;
    @(negedge CLK);
    i_enq = 1'b0;
    check("full_enq_ignored_count", {27'b0, o_count}, DEPTH);
    check("full_enq_ignored_ready", {31'b0, o_ready}, 32'd1);
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH - 1 - i; j++)
        if (keys[j] > keys[j+1]) begin
          tmp = keys[j]; keys[j] = keys[j+1]; keys[j+1] = tmp;
        end
    for (int i = 0; i < DEPTH; i++) do_deq("drain_sorted", keys[i]);
    check("drain_empty", {31'b0, o_empty}, 32'd1);

    // Reset during sift-down of a 10-entry heap
    for (int i = 10; i >= 1; i--) do_enq(DW'(i));
    do_deq("pre_reset_deq", 1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("midsift_rst_count", {27'b0, o_count}, 32'd0);
    check("midsift_rst_ready", {31'b0, o_ready}, 32'd1);
    check("midsift_rst_empty", {31'b0, o_empty}, 32'd1);
    do_enq(9);
    do_deq("post_reset", 9);
    check("post_reset_empty", {31'b0, o_empty}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
